// File: rtl/rtlola_sum_monitor.sv
// Two-stage stream monitor: stage 1 captures a synchronous input event,
// stage 2 evaluates the sum, running sum and previous running sum.
module rtlola_sum_monitor (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] input_0,
    input  logic        new_input_0,
    input  logic [63:0] input_1,
    input  logic        new_input_1,
    output logic [63:0] output_0,
    output logic        output_0_aktv,
    output logic [63:0] output_1,
    output logic        output_1_aktv,
    output logic [63:0] output_2,
    output logic        output_2_aktv
);

    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_valid1;
    logic [63:0] r_sum;
    logic [63:0] r_out0;
    logic [63:0] r_out1;
    logic [63:0] r_out2;
    logic        r_aktv;

    logic        w_event;
    logic [63:0] w_o0;
    logic [63:0] w_sum_next;

    // An event needs both streams new in the same cycle; lone strobes are dropped.
    assign w_event    = new_input_0 & new_input_1;
    assign w_o0       = r_a + r_b;
    assign w_sum_next = r_sum + w_o0;

    // NOTE: every register here is written with <= so all stage-2 terms read
    // the pre-edge values of stage 1 and S, giving true one-event-per-cycle pipelining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_valid1 <= 1'b0;
            r_sum    <= '0;
            r_out0   <= '0;
            r_out1   <= '0;
            r_out2   <= '0;
            r_aktv   <= 1'b0;
        end else if (en) begin
            r_valid1 <= w_event;
            if (w_event) begin
                r_a <= input_0;
                r_b <= input_1;
            end
            r_aktv <= r_valid1;
            if (r_valid1) begin
                r_out0 <= w_o0;
                r_out1 <= w_sum_next;
                r_out2 <= r_sum;
                r_sum  <= w_sum_next;
            end
        end
    end

    assign output_0      = r_out0;
    assign output_1      = r_out1;
    assign output_2      = r_out2;
    assign output_0_aktv = r_aktv;
    assign output_1_aktv = r_aktv;
    assign output_2_aktv = r_aktv;

endmodule

// File: tb/tb_rtlola_sum_monitor.sv
// Self-checking bench for rtlola_sum_monitor: directed scenarios plus random
// traffic, checked against an event-queue reference model.
module tb_rtlola_sum_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [63:0] input_0 = '0;
    logic        new_input_0 = 1'b0;
    logic [63:0] input_1 = '0;
    logic        new_input_1 = 1'b0;
    logic [63:0] output_0;
    logic        output_0_aktv;
    logic [63:0] output_1;
    logic        output_1_aktv;
    logic [63:0] output_2;
    logic        output_2_aktv;

    int n_cmp = 0;
    int n_bad = 0;

    rtlola_sum_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .input_0      (input_0),
        .new_input_0  (new_input_0),
        .input_1      (input_1),
        .new_input_1  (new_input_1),
        .output_0     (output_0),
        .output_0_aktv(output_0_aktv),
        .output_1     (output_1),
        .output_1_aktv(output_1_aktv),
        .output_2     (output_2),
        .output_2_aktv(output_2_aktv)
    );

    always #5 clk = ~clk;

    // Reference model: accepted events wait in a queue tagged with the enabled
    // edge at which their results become visible.
    typedef struct {
        longint unsigned due;
        logic [63:0]     a;
        logic [63:0]     b;
    } ev_t;

    ev_t             q[$];
    longint unsigned en_edges = 0;
    logic [63:0]     m_o0 = '0, m_o1 = '0, m_o2 = '0, m_sum = '0;
    logic            m_aktv = 1'b0;

    typedef struct {
        logic        r;
        logic        e;
        logic        n0;
        logic        n1;
        logic [63:0] a;
        logic [63:0] b;
    } stim_t;

    // Drive one cycle, advance the model for that edge, sample 1 time unit later.
    task automatic step(input stim_t s);
        ev_t ev;
        rst = s.r; en = s.e;
        new_input_0 = s.n0; input_0 = s.a;
        new_input_1 = s.n1; input_1 = s.b;
        @(posedge clk);
        if (s.r) begin
            q.delete();
            m_o0 = '0; m_o1 = '0; m_o2 = '0; m_sum = '0; m_aktv = 1'b0;
        end else if (s.e) begin
            en_edges++;
            m_aktv = 1'b0;
            if (q.size() > 0 && q[0].due == en_edges) begin
                ev     = q.pop_front();
                m_o0   = ev.a + ev.b;
                m_o2   = m_sum;
                m_sum  = m_sum + m_o0;
                m_o1   = m_sum;
                m_aktv = 1'b1;
            end
            if (s.n0 && s.n1) q.push_back('{en_edges + 1, s.a, s.b});
        end
        #1;
    endtask

    function automatic stim_t idle();
        return '{1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0};
    endfunction

    function automatic stim_t evt(input logic [63:0] a, input logic [63:0] b);
        return '{1'b0, 1'b1, 1'b1, 1'b1, a, b};
    endfunction

    function automatic stim_t do_rst();
        return '{1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0};
    endfunction

    task automatic test_reset();
        step(do_rst());
        step(do_rst());
        n_cmp++;
        if ({output_0, output_1, output_2} !== 192'd0 ||
            {output_0_aktv, output_1_aktv, output_2_aktv} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset: got o0=%h o1=%h o2=%h aktv=%b%b%b, want all zero",
                     output_0, output_1, output_2, output_0_aktv, output_1_aktv, output_2_aktv);
        end
    endtask

    // Run a stimulus table, checking every cycle against the model; collects
    // output_1 on each aktv pulse for the caller's literal checks.
    task automatic run_table(input string name, input stim_t tbl[$], output logic [63:0] o1s[$]);
        o1s.delete();
        foreach (tbl[i]) begin
            step(tbl[i]);
            if (output_0_aktv) o1s.push_back(output_1);
            n_cmp++;
            if ({output_0, output_1, output_2} !== {m_o0, m_o1, m_o2} ||
                {output_0_aktv, output_1_aktv, output_2_aktv} !== {3{m_aktv}}) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got o0=%h o1=%h o2=%h aktv=%b%b%b, want o0=%h o1=%h o2=%h aktv=%b",
                         name, i, output_0, output_1, output_2,
                         output_0_aktv, output_1_aktv, output_2_aktv, m_o0, m_o1, m_o2, m_aktv);
            end
        end
    endtask

    task automatic test_spaced();
        stim_t t[$];
        logic [63:0] o1s[$];
        t.push_back(do_rst());
        for (int k = 1; k <= 4; k++) begin
            t.push_back(evt(64'(k), 64'(k)));
            t.push_back(idle());
        end
        t.push_back(idle());
        run_table("spaced", t, o1s);
        n_cmp++;
        if (o1s.size() != 4 || o1s[0] !== 64'd2 || o1s[1] !== 64'd6 ||
            o1s[2] !== 64'd12 || o1s[3] !== 64'd20) begin
            n_bad++;
            $display("FAIL spaced_o1_seq: got %0d pulses, want 4 pulses with output_1 2,6,12,20",
                     o1s.size());
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        logic [63:0] o1s[$];
        t.push_back(do_rst());
        for (int k = 1; k <= 4; k++) t.push_back(evt(64'(k), 64'(k)));
        t.push_back(idle());
        t.push_back(idle());
        run_table("back_to_back", t, o1s);
        n_cmp++;
        if (o1s.size() != 4 || o1s[3] !== 64'd20) begin
            n_bad++;
            $display("FAIL b2b_o1_seq: got %0d pulses last=%0d, want 4 pulses last=20",
                     o1s.size(), (o1s.size() > 0) ? o1s[o1s.size()-1] : 64'd0);
        end
    endtask

    task automatic test_partial();
        stim_t t[$];
        logic [63:0] o1s[$];
        t.push_back(evt(64'd10, 64'd20));
        t.push_back(idle());
        t.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'd5, 64'd0});
        t.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 64'd9});
        t.push_back(idle());
        t.push_back(idle());
        run_table("partial", t, o1s);
        n_cmp++;
        if (o1s.size() != 1) begin
            n_bad++;
            $display("FAIL partial_pulses: got %0d pulses, want 1", o1s.size());
        end
    endtask

    task automatic test_overflow();
        stim_t t[$];
        logic [63:0] o1s[$];
        t.push_back(do_rst());
        t.push_back(evt(64'h7FFF_FFFF_FFFF_FFFF, 64'd1));
        t.push_back(idle());
        run_table("overflow", t, o1s);
        n_cmp++;
        if (output_0 !== 64'h8000_0000_0000_0000 || output_1 !== 64'h8000_0000_0000_0000 ||
            output_2 !== 64'd0) begin
            n_bad++;
            $display("FAIL overflow_wrap: got o0=%h o1=%h o2=%h, want 8000000000000000/8000000000000000/0",
                     output_0, output_1, output_2);
        end
    endtask

    task automatic test_enable();
        stim_t t[$];
        logic [63:0] o1s[$];
        t.push_back(do_rst());
        t.push_back(evt(64'd3, 64'd4));
        for (int k = 0; k < 3; k++) t.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 64'd50, 64'd60});
        run_table("enable_hold", t, o1s);
        n_cmp++;
        if (output_0_aktv !== 1'b0 || output_0 !== 64'd0) begin
            n_bad++;
            $display("FAIL enable_hold: got o0=%h aktv=%b, want 0/0", output_0, output_0_aktv);
        end
        t.delete();
        t.push_back(idle());
        t.push_back(idle());
        run_table("enable_resume", t, o1s);
        n_cmp++;
        if (o1s.size() != 1 || o1s[0] !== 64'd7) begin
            n_bad++;
            $display("FAIL enable_resume: got %0d pulses, want 1 pulse with output_1=7", o1s.size());
        end
    endtask

    task automatic test_reset_mid();
        stim_t t[$];
        logic [63:0] o1s[$];
        t.push_back(do_rst());
        t.push_back(evt(64'd100, 64'd200));
        t.push_back(do_rst());
        t.push_back(idle());
        run_table("reset_mid", t, o1s);
        n_cmp++;
        if (o1s.size() != 0 || output_0 !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mid_drop: got %0d pulses o0=%h, want 0 pulses o0=0", o1s.size(), output_0);
        end
        t.delete();
        t.push_back(evt(64'd1, 64'd2));
        t.push_back(idle());
        run_table("reset_mid_after", t, o1s);
        n_cmp++;
        if (output_1 !== 64'd3 || output_2 !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mid_after: got o1=%h o2=%h, want 3/0", output_1, output_2);
        end
    endtask

    task automatic test_random();
        stim_t t[$];
        logic [63:0] o1s[$];
        stim_t s;
        t.push_back(do_rst());
        for (int k = 0; k < 400; k++) begin
            s.r  = ($urandom_range(0, 49) == 0);
            s.e  = ($urandom_range(0, 3) != 0);
            s.n0 = ($urandom_range(0, 3) != 0);
            s.n1 = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       s.a = 64'h7FFF_FFFF_FFFF_FFFF;
                1:       s.a = 64'h8000_0000_0000_0000;
                default: s.a = {$urandom, $urandom};
            endcase
            s.b = {$urandom, $urandom};
            t.push_back(s);
        end
        run_table("random", t, o1s);
    endtask

    initial begin
        test_reset();
        test_spaced();
        test_back_to_back();
        test_partial();
        test_overflow();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
